// File: rtl/arith_pkg.sv
// Shared arithmetic constants, result bundle and reference model.
// Used by the adder datapath and by scoreboards checking it.
package arith_pkg;

  localparam int FA_MAX_WIDTH = 64;

  typedef struct packed {
    logic        ovf;
    logic        cout;
    logic [63:0] sum;
  } fa_res_t;

  // Expected {ovf, cout, sum} of a + b + cin at width w (1..64).
  function automatic fa_res_t fa_ref(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic        cin,
    input int          w
  );
    logic [63:0] mask;
    logic [64:0] full;
    fa_res_t     r;
    mask  = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    full  = {1'b0, a & mask} + {1'b0, b & mask} + {64'd0, cin};
    r.sum  = full[63:0] & mask;
    r.cout = full[w];
    r.ovf  = (a[w-1] == b[w-1]) && (r.sum[w-1] != a[w-1]);
    return r;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Combinational single-bit full adder cell.
// Chained carry-to-carry to build a ripple adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/full_adder_reg.sv
// Registered ripple-carry adder: {cout, sum} = a + b + cin.
// One-cycle latency with valid strobe and signed overflow flag.
module full_adder_reg
  import arith_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
    $error("full_adder_reg: WIDTH out of range");
  end

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .sum  (s[i]),
      .cout (c[i+1])
    );
  end

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;
  logic             valid_d, valid_q;

  // Capture a new result on in_valid, otherwise hold and drop valid.
  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    if (in_valid) begin
      sum_d   = s;
      cout_d  = c[WIDTH];
      ovf_d   = c[WIDTH-1] ^ c[WIDTH];
      valid_d = 1'b1;
    end
  end

  // Result registers; reset discards any same-cycle result.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_full_adder_reg.sv
// Scoreboard bench for full_adder_reg at WIDTH=1 and WIDTH=8.
// Stimulus pushes expected results; monitors pop on out_valid.
module tb_full_adder_reg;
  import arith_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv1, iv8;
  logic [0:0] a1, b1;
  logic       c1;
  logic [7:0] a8, b8;
  logic       c8;
  logic       ov1, ov8;
  logic [0:0] s1;
  logic [7:0] s8;
  logic       co1, co8, of1, of8;

  int total = 0;
  int bad   = 0;

  fa_res_t q1[$];
  fa_res_t q8[$];

  always #5 clk = ~clk;

  full_adder_reg #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1),
    .a(a1), .b(b1), .cin(c1),
    .out_valid(ov1), .sum(s1), .cout(co1), .ovf(of1)
  );

  full_adder_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8),
    .a(a8), .b(b8), .cin(c8),
    .out_valid(ov8), .sum(s8), .cout(co8), .ovf(of8)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic fa_res_t mk(input logic [63:0] s,
                                 input logic co, input logic of);
    fa_res_t r;
    r.sum  = s;
    r.cout = co;
    r.ovf  = of;
    return r;
  endfunction

  // Monitor for the 1-bit adder.
  always @(negedge clk) begin
    if (ov1 === 1'b1) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL w1_unexpected got=1 want=0");
      end else begin
        fa_res_t e;
        e = q1.pop_front();
        chk("w1_sum", {63'd0, s1}, e.sum);
        chk("w1_cout", {63'd0, co1}, {63'd0, e.cout});
        chk("w1_ovf", {63'd0, of1}, {63'd0, e.ovf});
      end
    end
  end

  // Monitor for the 8-bit adder.
  always @(negedge clk) begin
    if (ov8 === 1'b1) begin
      if (q8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL w8_unexpected got=1 want=0");
      end else begin
        fa_res_t e;
        e = q8.pop_front();
        chk("w8_sum", {56'd0, s8}, e.sum);
        chk("w8_cout", {63'd0, co8}, {63'd0, e.cout});
        chk("w8_ovf", {63'd0, of8}, {63'd0, e.ovf});
      end
    end
  end

  // a, b, cin, sum, cout, ovf
  logic [5:0] tt [8] = '{
    6'b000_000, 6'b001_101, 6'b010_100, 6'b011_010,
    6'b100_100, 6'b101_010, 6'b110_011, 6'b111_110
  };

  task automatic drive1(input logic a, input logic b, input logic ci);
    @(negedge clk);
    iv1 = 1'b1;
    a1  = a;
    b1  = b;
    c1  = ci;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b,
                        input logic ci);
    @(negedge clk);
    iv8 = 1'b1;
    a8  = a;
    b8  = b;
    c8  = ci;
  endtask

  initial begin
    rst = 1'b1;
    iv1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
    iv8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ov1", {63'd0, ov1}, 64'd0);
    chk("rst_s1", {63'd0, s1}, 64'd0);
    chk("rst_ov8", {63'd0, ov8}, 64'd0);
    chk("rst_s8", {56'd0, s8}, 64'd0);
    rst = 1'b0;

    // Truth table, one vector per cycle.
    for (int i = 0; i < 8; i++) begin
      logic [5:0] v;
      v = tt[i];
      if (i != 0) @(negedge clk);
      iv1 = 1'b1;
      a1 = v[5]; b1 = v[4]; c1 = v[3];
      q1.push_back(mk({63'd0, v[2]}, v[1], v[0]));
    end

    // Reset with valid operands discards the result.
    @(negedge clk);
    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; iv1 = 1'b1;
    @(negedge clk);
    chk("rst_mid_s", {63'd0, s1}, 64'd0);
    chk("rst_mid_co", {63'd0, co1}, 64'd0);
    chk("rst_mid_of", {63'd0, of1}, 64'd0);
    chk("rst_mid_ov", {63'd0, ov1}, 64'd0);
    rst = 1'b0;
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b0; iv1 = 1'b1;
    q1.push_back(mk(64'd1, 1'b0, 1'b0));

    // Hold behaviour.
    drive1(1'b1, 1'b1, 1'b1);
    q1.push_back(mk(64'd1, 1'b1, 1'b0));
    @(negedge clk);
    iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    @(negedge clk);
    chk("hold_s", {63'd0, s1}, 64'd1);
    chk("hold_co", {63'd0, co1}, 64'd1);
    chk("hold_ov", {63'd0, ov1}, 64'd0);

    // WIDTH=8 wrap and overflow corners.
    drive8(8'hFF, 8'h00, 1'b1);
    q8.push_back(mk(64'h00, 1'b1, 1'b0));
    drive8(8'h7F, 8'h01, 1'b0);
    q8.push_back(mk(64'h80, 1'b0, 1'b1));
    drive8(8'h80, 8'h80, 1'b0);
    q8.push_back(mk(64'h00, 1'b1, 1'b1));
    drive8(8'hA5, 8'h5A, 1'b1);
    q8.push_back(mk(64'h00, 1'b1, 1'b0));

    // Streaming random vectors, one per cycle.
    for (int i = 0; i < 16; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      drive8(ra, rb, rc);
      chk("stream_ov", {63'd0, ov8}, 64'd1);
      q8.push_back(fa_ref({56'd0, ra}, {56'd0, rb}, rc, 8));
    end
    @(negedge clk);
    chk("stream_last_ov", {63'd0, ov8}, 64'd1);
    iv8 = 1'b0;
    a8 = 'x;
    b8 = 'x;
    @(negedge clk);
    chk("xfree_ov", {63'd0, ov8}, 64'd0);
    chk("xfree_unk", {63'd0, $isunknown({s8, co8, of8})}, 64'd0);

    repeat (2) @(negedge clk);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("q8_drained", 64'(q8.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/full_adder_reg.md
Name: full_adder_reg

Overview:
- Registered ripple-carry adder computing {cout, sum} = a + b + cin.
- WIDTH defaults to 1, so the default build is the classic single-bit full adder with a one-cycle registered result.
- Used as the arithmetic leaf in datapath blocks that need a carry-in, carry-out and signed-overflow flag with a simple valid strobe.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_valid  input  1  operands a/b/cin are valid this cycle.
- a  input  WIDTH  addend A, unsigned (also interpreted two's-complement for ovf).
- b  input  WIDTH  addend B.
- cin  input  1  carry into bit 0.
- out_valid  output  1  sum/cout/ovf hold a freshly computed result.
- sum  output  WIDTH  registered low WIDTH bits of a + b + cin.
- cout  output  1  registered carry out of the MSB.
- ovf  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. No asynchronous reset path.
- Combinational core:
  - Bit i uses s_i = a_i ^ b_i ^ c_i and c_{i+1} = (a_i & b_i) | (c_i & (a_i ^ b_i)).
  - c_0 = cin; cout = c_WIDTH; ovf = c_{WIDTH-1} ^ c_WIDTH.
  - For WIDTH=1, ovf = cin ^ cout.
- Arithmetic: the result is exactly {cout, sum} = a + b + cin as unsigned WIDTH+1-bit values. No saturation; wrap-around is modulo 2^WIDTH, with the overflow visible in cout.
- Latency: one cycle. Operands sampled on edge N appear on sum/cout/ovf after edge N, with out_valid=1 during cycle N+1.
- On each rising clk:
  - rst=1: sum=0, cout=0, ovf=0, out_valid=0. in_valid is ignored that cycle.
  - rst=0, in_valid=1: register the new sum/cout/ovf; out_valid<=1.
  - rst=0, in_valid=0: sum/cout/ovf hold their previous values; out_valid<=0.
- Back-to-back in_valid produces one result per cycle; no backpressure and no stall input.
- Reset mid-stream: a result computed in the same cycle that rst is high is discarded. The first in_valid after rst deasserts yields out_valid one cycle later.
- Outputs are X-free after the first reset edge, even with X on a/b when in_valid=0.
- Power-up state before the first reset is unspecified; the bench must assert rst for at least one edge.

Decomposition:
- Shared package (arith_pkg): constant FA_MAX_WIDTH = 64 and a function returning the expected {cout,sum} for scoreboards.
- Sub-module full_adder_cell: purely combinational 1-bit cell (a, b, cin -> sum, cout).
  - full_adder_reg instantiates WIDTH of these in a generate loop chained carry-to-carry.
  - The registered stage (flops + out_valid) lives in full_adder_reg.

Test Plan:
- WIDTH=1 truth table, one vector per cycle with in_valid=1:
  - (a,b,cin) = 000 -> sum=0, cout=0.
  - (a,b,cin) = 011 -> sum=0, cout=1.
  - (a,b,cin) = 101 -> sum=0, cout=1.
  - (a,b,cin) = 110 -> sum=0, cout=1.
  - (a,b,cin) = 111 -> sum=1, cout=1.
  - Each vector has out_valid=1 the following cycle.
  - Also cover 001 -> sum=1, cout=0; 010 -> 1,0; 100 -> 1,0.
- Reset: rst=1 with a=b=cin=1 and in_valid=1 -> next cycle sum=0, cout=0, ovf=0, out_valid=0.
  - Deassert rst with a=1, b=0, cin=0, in_valid=1 -> sum=1, cout=0 one cycle later.
- Hold: apply a=1, b=1, cin=1 (result 1,1), then in_valid=0 with a=0, b=0 -> sum stays 1, cout stays 1, out_valid=0.
- WIDTH=8 wrap/overflow:
  - a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1, ovf=0.
  - a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
  - a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1.
- WIDTH=8 streaming: 16 back-to-back random vectors with in_valid=1 -> each result matches the package reference function exactly one cycle later, with out_valid continuously 1.
